// File: rtl/control_sequencer.sv
// SAP-style fetch/execute sequencer: one-hot T-state register plus sticky halt flag,
// with control strobes decoded from (T-state, opcode) and gated by run/halt/reset.
module control_sequencer #(
    parameter int unsigned OPC_W = 4,
    parameter int unsigned NUM_T = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [OPC_W-1:0] opcode,
    output logic             pc_oe,
    output logic             pc_inc,
    output logic             mar_load_n,
    output logic             ram_oe,
    output logic             ir_load_n,
    output logic             ir_oe,
    output logic             regb_load_n,
    output logic             alu_oe,
    output logic             alu_sub,
    output logic             acc_load_n,
    output logic             acc_oe,
    output logic             out_load_n,
    output logic             halted,
    output logic [NUM_T-1:0] t_state
);

    typedef enum logic [NUM_T-1:0] {
        T0 = NUM_T'(1),
        T1 = NUM_T'(2),
        T2 = NUM_T'(4),
        T3 = NUM_T'(8),
        T4 = NUM_T'(16),
        T5 = NUM_T'(32)
    } tstate_e;

    typedef enum logic [OPC_W-1:0] {
        OP_LDA = OPC_W'(0),
        OP_ADD = OPC_W'(1),
        OP_SUB = OPC_W'(2),
        OP_OUT = OPC_W'(14),
        OP_HLT = OPC_W'(15)
    } opcode_e;

    tstate_e state_q;
    logic    halted_q;
    logic    active;

    function automatic logic is_onehot(input logic [NUM_T-1:0] v);
        return (v != '0) && ((v & (v - NUM_T'(1))) == '0);
    endfunction

    // Corrupted (non-one-hot) state recovers to T0 even while paused or halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= T0;
            halted_q <= 1'b0;
        end else if (!is_onehot(state_q)) begin
            state_q <= T0;
        end else if (run && !halted_q) begin
            case (state_q)
                T0: state_q <= T1;
                T1: state_q <= T2;
                T2: state_q <= T3;
                T3: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: state_q <= T4;
                        OP_HLT:                 halted_q <= 1'b1;
                        default:                state_q <= T0;
                    endcase
                end
                T4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        state_q <= T5;
                    end else begin
                        state_q <= T0;
                    end
                end
                T5:      state_q <= T0;
                default: state_q <= T0;
            endcase
        end
    end

    assign active  = run && !halted_q && !rst;
    assign halted  = halted_q;
    assign t_state = state_q;

    always_comb begin
        pc_oe       = 1'b0;
        pc_inc      = 1'b0;
        mar_load_n  = 1'b1;
        ram_oe      = 1'b0;
        ir_load_n   = 1'b1;
        ir_oe       = 1'b0;
        regb_load_n = 1'b1;
        alu_oe      = 1'b0;
        alu_sub     = 1'b0;
        acc_load_n  = 1'b1;
        acc_oe      = 1'b0;
        out_load_n  = 1'b1;
        if (active) begin
            case (state_q)
                T0: begin
                    pc_oe      = 1'b1;
                    mar_load_n = 1'b0;
                end
                T1: pc_inc = 1'b1;
                T2: begin
                    ram_oe    = 1'b1;
                    ir_load_n = 1'b0;
                end
                T3: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ir_oe      = 1'b1;
                            mar_load_n = 1'b0;
                        end
                        OP_OUT: begin
                            acc_oe     = 1'b1;
                            out_load_n = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    case (opcode)
                        OP_LDA: begin
                            ram_oe     = 1'b1;
                            acc_load_n = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_oe      = 1'b1;
                            regb_load_n = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_oe     = 1'b1;
                        alu_sub    = (opcode == OP_SUB);
                        acc_load_n = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer against an instruction-level model.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst, run;
    logic [3:0] opcode;
    logic       pc_oe, pc_inc, mar_load_n, ram_oe, ir_load_n, ir_oe, regb_load_n;
    logic       alu_oe, alu_sub, acc_load_n, acc_oe, out_load_n, halted;
    logic [5:0] t_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: position within the current instruction plus halt flag.
    int   m_step = 0;
    logic m_halt = 1'b0;

    control_sequencer #(.OPC_W(4), .NUM_T(6)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .pc_oe(pc_oe), .pc_inc(pc_inc), .mar_load_n(mar_load_n), .ram_oe(ram_oe),
        .ir_load_n(ir_load_n), .ir_oe(ir_oe), .regb_load_n(regb_load_n),
        .alu_oe(alu_oe), .alu_sub(alu_sub), .acc_load_n(acc_load_n), .acc_oe(acc_oe),
        .out_load_n(out_load_n), .halted(halted), .t_state(t_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int instr_len(input logic [3:0] op);
        if (op == 4'h0) return 5;
        if (op == 4'h1 || op == 4'h2) return 6;
        return 4;
    endfunction

    // Expected strobe vector, ordered:
    // pc_oe pc_inc mar_load_n ram_oe ir_load_n ir_oe regb_load_n alu_oe alu_sub acc_load_n acc_oe out_load_n
    function automatic logic [11:0] exp_strobes(input int step, input logic [3:0] op, input logic act);
        logic pco, pci, mar, ram, irl, iro, rb, alo, sub, accl, acco, outl;
        logic arith;
        pco = 0; pci = 0; mar = 1; ram = 0; irl = 1; iro = 0;
        rb = 1; alo = 0; sub = 0; accl = 1; acco = 0; outl = 1;
        arith = (op == 4'h1) || (op == 4'h2);
        if (act) begin
            if (step == 0) begin pco = 1; mar = 0; end
            if (step == 1) pci = 1;
            if (step == 2) begin ram = 1; irl = 0; end
            if (step == 3 && (op == 4'h0 || arith)) begin iro = 1; mar = 0; end
            if (step == 3 && op == 4'hE) begin acco = 1; outl = 0; end
            if (step == 4 && op == 4'h0) begin ram = 1; accl = 0; end
            if (step == 4 && arith) begin ram = 1; rb = 0; end
            if (step == 5 && arith) begin alo = 1; accl = 0; sub = (op == 4'h2); end
        end
        return {pco, pci, mar, ram, irl, iro, rb, alo, sub, accl, acco, outl};
    endfunction

    task automatic step_cycle(input logic r, input logic rn, input logic [3:0] op);
        logic [11:0] got;
        int          n_en;
        rst = r; run = rn; opcode = op;
        @(negedge clk);
        got  = {pc_oe, pc_inc, mar_load_n, ram_oe, ir_load_n, ir_oe, regb_load_n,
                alu_oe, alu_sub, acc_load_n, acc_oe, out_load_n};
        n_en = int'(pc_oe) + int'(ram_oe) + int'(ir_oe) + int'(alu_oe) + int'(acc_oe);
        chk("strobes", {4'h0, got}, {4'h0, exp_strobes(m_step, op, rn && !m_halt && !r)});
        chk("t_state", {10'h0, t_state}, 16'(1) << m_step);
        chk("halted", {15'h0, halted}, {15'h0, m_halt});
        chk("bus_single_driver", {15'h0, n_en <= 1}, 16'h1);
        chk("t_state_onehot", {15'h0, $onehot(t_state)}, 16'h1);
        @(posedge clk);
        cyc++;
        if (r) begin
            m_step = 0;
            m_halt = 1'b0;
        end else if (rn && !m_halt) begin
            if (m_step == 3 && op == 4'hF) m_halt = 1'b1;
            else if (m_step + 1 == instr_len(op)) m_step = 0;
            else m_step = m_step + 1;
        end
        #1;
    endtask

    task automatic run_instr(input logic [3:0] op);
        do step_cycle(1'b0, 1'b1, op); while (m_step != 0);
    endtask

    initial begin
        logic [3:0] cur_op;
        logic       r, rn;
        rst = 1'b1; run = 1'b1; opcode = 4'h0;
        @(posedge clk);
        #1;
        repeat (3) step_cycle(1'b1, 1'b1, 4'h0);

        run_instr(4'h0);
        run_instr(4'h1);
        run_instr(4'h2);
        run_instr(4'hE);
        run_instr(4'h5);

        repeat (4) step_cycle(1'b0, 1'b1, 4'hF);
        repeat (10) step_cycle(1'b0, 1'b1, 4'hF);
        step_cycle(1'b1, 1'b1, 4'hF);

        step_cycle(1'b0, 1'b1, 4'h0);
        repeat (3) step_cycle(1'b0, 1'b0, 4'h0);
        run_instr(4'h0);

        cur_op = 4'h0;
        for (int i = 0; i < 500; i++) begin
            if (m_step == 0) cur_op = 4'($urandom_range(0, 15));
            rn = ($urandom_range(0, 3) != 0);
            r  = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0);
            step_cycle(r, rn, cur_op);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
